// File: rtl/bip_pkg.sv
// Shared definitions for the BIP sequencer: opcodes, accumulator mux codes,
// FSM state encoding, strobe bundle and default widths.
package bip_pkg;

  localparam int DB_DEF   = 16;
  localparam int PC_W_DEF = 11;
  localparam int OPC_W    = 5;

  localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SELA_RAM = 2'd0;
  localparam logic [1:0] SELA_IMM = 2'd1;
  localparam logic [1:0] SELA_ALU = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic       wr_acc;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       wr_ram;
    logic       rd_ram;
  } strobe_t;

  localparam strobe_t STROBE_NONE = '0;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder. Produces the strobe set for the accumulator,
// ALU and data RAM; everything is forced to zero unless the sequencer is in EXEC.
module bip_decoder
  import bip_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_exec,
  output strobe_t          o_strobe
);

  // Map opcode to strobes; unknown opcodes fall through as NOP
  always_comb begin
    o_strobe = STROBE_NONE;
    if (i_exec) begin
      case (i_opcode)
        OP_STO: begin
          o_strobe.wr_ram = 1'b1;
        end
        OP_LD: begin
          o_strobe.rd_ram = 1'b1;
          o_strobe.wr_acc = 1'b1;
          o_strobe.sel_a  = SELA_RAM;
        end
        OP_LDI: begin
          o_strobe.wr_acc = 1'b1;
          o_strobe.sel_a  = SELA_IMM;
        end
        OP_ADD, OP_SUB: begin
          o_strobe.rd_ram = 1'b1;
          o_strobe.wr_acc = 1'b1;
          o_strobe.sel_a  = SELA_ALU;
          o_strobe.sel_b  = 1'b0;
          o_strobe.op     = (i_opcode == OP_SUB);
        end
        OP_ADDI, OP_SUBI: begin
          o_strobe.wr_acc = 1'b1;
          o_strobe.sel_a  = SELA_ALU;
          o_strobe.sel_b  = 1'b1;
          o_strobe.op     = (i_opcode == OP_SUBI);
        end
        default: begin
          o_strobe = STROBE_NONE;
        end
      endcase
    end
  end

endmodule

// File: rtl/bip_control.sv
// BIP instruction sequencer: program counter, fetch/execute FSM and decode.
// Optional macro BIP_CYCLE_COUNT_EN adds a saturating CycleCount output that
// counts cycles spent in FETCH and EXEC.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for Start, PC presented, no strobes
// ST_FETCH | program memory registers Instr at PC
// ST_EXEC  | Instr decoded, strobes valid for this one cycle
// ST_HALT  | HLT executed, Halted high, only Reset leaves
module bip_control
  import bip_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int DB   = DB_DEF
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [DB-1:0]   Instr,
  output logic [PC_W-1:0] InstrAddr,
  output logic [DB-6:0]   Operand,
  output logic            WrAcc,
  output logic [1:0]      SelA,
  output logic            SelB,
  output logic            Op,
  output logic            WrRam,
  output logic            RdRam,
  output logic            Halted
`ifdef BIP_CYCLE_COUNT_EN
  ,
  output logic [31:0]     CycleCount
`endif
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [OPC_W-1:0]  w_opcode;
  logic              w_exec;
  strobe_t           w_strobe;

  assign w_opcode = Instr[DB-1:DB-5];
  assign w_exec   = (r_state == ST_EXEC);

  // State and program counter registers; reset drops strobes immediately
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Next-state and PC advance; PC wraps naturally at 2^PC_W
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_IDLE: begin
        if (Start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_opcode == OP_HLT) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_pc_nxt    = r_pc + PC_W'(1);
          w_state_nxt = ST_FETCH;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  bip_decoder u_decoder (
    .i_opcode (w_opcode),
    .i_exec   (w_exec),
    .o_strobe (w_strobe)
  );

  assign InstrAddr = r_pc;
  assign Operand   = Instr[DB-6:0];
  assign WrAcc     = w_strobe.wr_acc;
  assign SelA      = w_strobe.sel_a;
  assign SelB      = w_strobe.sel_b;
  assign Op        = w_strobe.op;
  assign WrRam     = w_strobe.wr_ram;
  assign RdRam     = w_strobe.rd_ram;
  assign Halted    = (r_state == ST_HALT);

`ifdef BIP_CYCLE_COUNT_EN
  logic [31:0] r_cycle_count;

  // Count active sequencing cycles, holding at all-ones
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_cycle_count <= '0;
    end else if (((r_state == ST_FETCH) || (r_state == ST_EXEC)) &&
                 (r_cycle_count != 32'hFFFF_FFFF)) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign CycleCount = r_cycle_count;
`endif

endmodule
